uart_tx_cfg: RTL
================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, number of data bits per frame; legal range 5..9.
REQ-002 SHALL provide parameter OVERSAMPLE, default 16, number of baud_tick pulses per bit period; legal range 2..64.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 baud_tick  input  1  one-cycle enable pulse from the baud generator.
REQ-006 tx_start  input  1  request to send; sampled only when tx_busy=0.
REQ-007 data_in  input  DATA_BITS  frame payload, captured on acceptance.
REQ-008 parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none; captured on acceptance.
REQ-009 stop2  input  1  0 one stop bit, 1 two stop bits; captured on acceptance.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 tx_busy  output  1  high from the cycle after acceptance until the frame completes.
REQ-012 tx_done  output  1  single-cycle pulse at frame completion.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-014 Acceptance: in IDLE with tx_start=1 on a clock edge, SHALL capture data_in, parity_mode and stop2, clear the tick and bit counters, enter START, and set tx_busy=1.
REQ-015 tx SHALL be registered, and SHALL go low on the edge that enters START (the acceptance edge).
REQ-016 Each bit period SHALL last exactly OVERSAMPLE baud_tick pulses; the state or bit SHALL advance on the edge where the tick counter equals OVERSAMPLE-1 and baud_tick=1.
REQ-017 Cycles without baud_tick SHALL hold all state, counters and tx.
REQ-018 START->DATA at the end of the period; tx SHALL present data bit 0 on the same edge.
REQ-019 DATA SHALL send DATA_BITS bits LSB first. Each new bit SHALL appear on the edge that ends the previous period, so tx never carries a stale bit.
REQ-020 After the last data bit: go to PARITY if the captured mode is even or odd, otherwise to STOP.
REQ-021 Parity bit: even mode SHALL send XOR of the captured data; odd mode SHALL send its inverse.
REQ-022 STOP SHALL drive tx=1 for 1 bit period, or 2 if stop2 was captured as 1.
REQ-023 At the end of STOP the block SHALL enter IDLE, deassert tx_busy, and pulse tx_done for exactly one cycle.
REQ-024 tx_start while tx_busy=1 SHALL be ignored. Changes to data_in, parity_mode or stop2 mid-frame SHALL have no effect.
REQ-025 If tx_start=1 in the cycle tx_done pulses, the next frame SHALL be accepted; its start bit SHALL begin that edge with no idle bit in between.
REQ-026 Counters SHALL be sized for the parameter values with no wrap-around inside a frame. The bit counter SHALL be sized to hold DATA_BITS-1.
REQ-027 Any unreachable state encoding SHALL return to IDLE with tx=1, tx_busy=0 and tx_done=0.
REQ-028 Frame length in bit periods SHALL be 1 + DATA_BITS + (parity?1:0) + (stop2?2:1).

Reset
REQ-029 With rst=1 on a clock edge, the block SHALL set state=IDLE, tx=1, tx_busy=0, tx_done=0, and both counters=0.
REQ-030 rst SHALL take priority over all other inputs, including an in-progress frame and a simultaneous tx_start. The block SHALL not resume the aborted frame.
REQ-031 The captured data and configuration registers need no reset value.

Verification
REQ-032 Defaults, baud_tick every cycle, data_in=8'hA5, parity none, stop2=0 -> tx shows 0,1,0,1,0,0,1,0,1,1 with each bit held 16 cycles; tx_done pulses once, 160 cycles after acceptance.
REQ-033 data_in=8'h07 with even parity -> parity bit 1. With odd parity -> parity bit 0. Frame is 11 bit periods.
REQ-034 stop2=1, DATA_BITS=5, OVERSAMPLE=4, data_in=5'h1F -> the stop high lasts 8 ticks; total frame is 32 ticks.
REQ-035 baud_tick every 3rd cycle, tx_start pulsed again mid-frame with new data -> first frame is unaltered and the second request is dropped. tx_start held at the tx_done cycle -> a back-to-back frame starts immediately.
REQ-036 rst asserted during DATA -> next edge gives tx=1, tx_busy=0, no tx_done. A following tx_start sends a complete fresh frame.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional even/odd parity, one or two stop bits, paced by an oversampled
// baud tick.
module uart_tx_cfg #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [TICK_W-1:0]    tick_cnt, tick_cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic                 tx_n, busy_n, done_n;

  // Captured frame payload and configuration; the shift register feeds tx.
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_en, par_en_n;
  logic                 par_bit, par_bit_n;
  logic                 stop2_q, stop2_n;

  logic                 tick_end;

  assign tick_end = baud_tick && (tick_cnt == TICK_LAST);

  // Control state, counters and line outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
      tx       <= tx_n;
      tx_busy  <= busy_n;
      tx_done  <= done_n;
    end
  end

  // Payload/config capture registers carry no reset value.
  always_ff @(posedge clk) begin
    shreg   <= shreg_n;
    par_en  <= par_en_n;
    par_bit <= par_bit_n;
    stop2_q <= stop2_n;
  end

  // Next-state, counter, payload and output logic.
  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    tx_n       = tx;
    busy_n     = tx_busy;
    done_n     = 1'b0;
    shreg_n    = shreg;
    par_en_n   = par_en;
    par_bit_n  = par_bit;
    stop2_n    = stop2_q;

    // Tick counter runs only while a frame is active; IDLE overrides below.
    if (baud_tick) begin
      tick_cnt_n = tick_end ? '0 : tick_cnt + TICK_W'(1);
    end

    case (state)
      IDLE: begin
        tick_cnt_n = '0;
        bit_cnt_n  = '0;
        tx_n       = 1'b1;
        busy_n     = 1'b0;
        if (tx_start) begin
          shreg_n   = data_in;
          par_en_n  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          par_bit_n = (^data_in) ^ (parity_mode == 2'b10);
          stop2_n   = stop2;
          state_n   = START;
          tx_n      = 1'b0;
          busy_n    = 1'b1;
        end
      end

      START: begin
        if (tick_end) begin
          state_n   = DATA;
          bit_cnt_n = '0;
          tx_n      = shreg[0];
        end
      end

      DATA: begin
        if (tick_end) begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_n = '0;
            if (par_en) begin
              state_n = PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
          end
        end
      end

      PARITY: begin
        if (tick_end) begin
          state_n   = STOP;
          bit_cnt_n = '0;
          tx_n      = 1'b1;
        end
      end

      STOP: begin
        // bit_cnt counts stop periods here: 0 for the first, 1 for the second.
        if (tick_end) begin
          if (stop2_q && (bit_cnt == '0)) begin
            bit_cnt_n = BIT_W'(1);
          end else begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            tx_n      = 1'b1;
            busy_n    = 1'b0;
            done_n    = 1'b1;
          end
        end
      end

      default: begin
        state_n    = IDLE;
        tick_cnt_n = '0;
        bit_cnt_n  = '0;
        tx_n       = 1'b1;
        busy_n     = 1'b0;
        done_n     = 1'b0;
      end
    endcase
  end

endmodule
